// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the tick counter / 7-segment display slice.
//   DIGIT_W   - width of one counter digit (hex nibble or BCD digit)
//   SEG_GLYPH - active-high segment patterns for 0-F, bit 0 = segment a, bit 6 = g
//   calc_div  - clock cycles per tick; 0 when the tick rate is unusable
package seg7_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [6:0] SEG_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
      7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
      7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
      7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
   };

   function automatic int calc_div(input int clk_hz, input int tick_hz);
      if (tick_hz <= 0) return 0;
      return clk_hz / tick_hz;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational glyph lookup for one digit.
//   ACTIVE_LOW - 1 inverts the pattern so a lit segment drives 0
//   digit      - 4-bit value 0..F
//   seg        - segments, bit 0 = a ... bit 6 = g
module seg7_decoder
   import seg7_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic [DIGIT_W-1:0] digit,
   output logic [6:0]         seg
);

   logic [6:0] glyph;

   assign glyph = SEG_GLYPH[digit];
   assign seg   = ACTIVE_LOW ? ~glyph : glyph;

endmodule

// File: rtl/tick_counter_7seg.sv
// tick_counter_7seg: programmable tick generator driving an N-digit up/down
// counter (hex or BCD) with registered 7-segment outputs.
//   iCLK, iRST_N    - clock, asynchronous active-low reset
//   iEN, iUP, iBCD  - step enable (sampled on tick cycles), direction, digit mode
//   iCLR, iLOAD     - synchronous clear / load (clear wins), never touch the divider
//   iLOAD_VAL       - load value, digit k at [4k+3:4k]; BCD digits above 9 clamp to 9
//   oTICK, oSQ      - one-cycle tick pulse every DIV cycles, 50 % square wave
//   oCOUNT, oWRAP   - counter value, one-cycle pulse on carry/borrow out of top digit
//   oHEX            - segments, digit k at [7k+6:7k], always matches oCOUNT
module tick_counter_7seg
   import seg7_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int TICK_HZ        = 1,
   parameter int DIGITS         = 4,
   parameter bit ACTIVE_LOW_SEG = 1'b1
) (
   input  logic                        iCLK,
   input  logic                        iRST_N,
   input  logic                        iEN,
   input  logic                        iUP,
   input  logic                        iBCD,
   input  logic                        iCLR,
   input  logic                        iLOAD,
   input  logic [DIGIT_W*DIGITS-1:0]   iLOAD_VAL,
   output logic                        oTICK,
   output logic                        oSQ,
   output logic [DIGIT_W*DIGITS-1:0]   oCOUNT,
   output logic                        oWRAP,
   output logic [7*DIGITS-1:0]         oHEX
);

   localparam int CW    = DIGIT_W * DIGITS;
   localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
   localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam logic [6:0] SEG_ZERO = ACTIVE_LOW_SEG ? ~SEG_GLYPH[0] : SEG_GLYPH[0];

   if (DIV < 2) begin : g_bad_div
      $error("tick_counter_7seg: CLK_HZ/TICK_HZ must be at least 2");
   end
   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("tick_counter_7seg: DIGITS must be 1..8");
   end

   // One digit of the ripple chain. With cin low the digit holds and passes no
   // carry, so only the low run of max (up) or zero (down) digits moves.
   // A BCD digit above 9 left over from hex mode snaps to 0 going up and to 9
   // going down without producing a carry/borrow of its own in the down case.
   function automatic logic [DIGIT_W:0] digit_step(
      input logic [DIGIT_W-1:0] d,
      input logic               up,
      input logic               bcd,
      input logic               cin
   );
      logic [DIGIT_W-1:0] nd;
      logic               cout;
      nd   = d;
      cout = 1'b0;
      if (cin) begin
         if (up) begin
            if (bcd) begin
               if (d >= 4'd9) begin
                  nd   = 4'd0;
                  cout = 1'b1;
               end else begin
                  nd = d + 4'd1;
               end
            end else begin
               nd   = d + 4'd1;
               cout = (d == 4'hF);
            end
         end else begin
            if (bcd) begin
               if (d == 4'd0) begin
                  nd   = 4'd9;
                  cout = 1'b1;
               end else if (d > 4'd9) begin
                  nd = 4'd9;
               end else begin
                  nd = d - 4'd1;
               end
            end else begin
               nd   = d - 4'd1;
               cout = (d == 4'd0);
            end
         end
      end
      return {cout, nd};
   endfunction

   logic [DIV_W-1:0]   div_cnt;
   logic               tick;
   logic               sq_q;
   logic [CW-1:0]      count_q;
   logic [CW-1:0]      count_d;
   logic [CW-1:0]      step_val;
   logic [CW-1:0]      load_fix;
   logic               step_carry;
   logic               wrap_q;
   logic               wrap_d;
   logic [7*DIGITS-1:0] hex_d;
   logic [7*DIGITS-1:0] hex_q;

   // Divider: free-running, only reset stops it.
   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         div_cnt <= '0;
         sq_q    <= 1'b0;
      end else begin
         if (tick) begin
            div_cnt <= '0;
            sq_q    <= ~sq_q;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_step
      logic               cin;
      logic               cout;
      logic [DIGIT_W-1:0] nib;
      if (k == 0) begin : g_first
         assign cin = 1'b1;
      end else begin : g_next
         assign cin = g_step[k-1].cout;
      end
      assign {cout, nib} = digit_step(count_q[DIGIT_W*k +: DIGIT_W], iUP, iBCD, cin);
      assign step_val[DIGIT_W*k +: DIGIT_W] = nib;
   end
   assign step_carry = g_step[DIGITS-1].cout;

   always_comb begin
      load_fix = iLOAD_VAL;
      for (int k = 0; k < DIGITS; k++) begin
         if (iBCD && (iLOAD_VAL[DIGIT_W*k +: DIGIT_W] > 4'd9)) begin
            load_fix[DIGIT_W*k +: DIGIT_W] = 4'd9;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      wrap_d  = 1'b0;
      if (iCLR) begin
         count_d = '0;
      end else if (iLOAD) begin
         count_d = load_fix;
      end else if (tick && iEN) begin
         count_d = step_val;
         wrap_d  = step_carry;
      end
   end

   // Decode the value about to be registered so oHEX and oCOUNT change together.
   for (genvar k = 0; k < DIGITS; k++) begin : g_seg
      seg7_decoder #(
         .ACTIVE_LOW (ACTIVE_LOW_SEG)
      ) u_dec (
         .digit (count_d[DIGIT_W*k +: DIGIT_W]),
         .seg   (hex_d[7*k +: 7])
      );
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
         hex_q   <= {DIGITS{SEG_ZERO}};
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
         hex_q   <= hex_d;
      end
   end

   assign oTICK  = tick;
   assign oSQ    = sq_q;
   assign oCOUNT = count_q;
   assign oWRAP  = wrap_q;
   assign oHEX   = hex_q;

endmodule

// File: tb/tb_tick_counter_7seg.sv
module tb_tick_counter_7seg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        up = 1'b1;
   logic        bcd = 1'b0;
   logic        clr = 1'b0;
   logic        load = 1'b0;
   logic [7:0]  load_val = 8'h00;
   logic        tick;
   logic        sq;
   logic        wrap;
   logic [7:0]  count;
   logic [13:0] hex;

   always #5 clk = ~clk;

   tick_counter_7seg #(
      .CLK_HZ         (10),
      .TICK_HZ        (1),
      .DIGITS         (2),
      .ACTIVE_LOW_SEG (1'b1)
   ) dut (
      .iCLK      (clk),
      .iRST_N    (rst_n),
      .iEN       (en),
      .iUP       (up),
      .iBCD      (bcd),
      .iCLR      (clr),
      .iLOAD     (load),
      .iLOAD_VAL (load_val),
      .oTICK     (tick),
      .oSQ       (sq),
      .oCOUNT    (count),
      .oWRAP     (wrap),
      .oHEX      (hex)
   );

   // Active-low glyphs for 0-F, segment a in bit 0.
   logic [6:0] glyph_al [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [13:0] exp_hex(input logic [7:0] c);
      return {glyph_al[c[7:4]], glyph_al[c[3:0]]};
   endfunction

   typedef struct {
      int         cyc;
      bit         imm;
      string      name;
      logic [7:0] cnt;
      logic       wrap;
      logic       tick;
      logic       sq;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   event chk_now;

   // Posedges since the last reset release; tick cycles sit at phase 9.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc = 0;
      else        cyc = cyc + 1;
   end

   initial begin
      forever begin
         @(negedge clk or chk_now);
         while (sb.size() > 0 && (sb[0].imm || sb[0].cyc <= cyc)) begin
            cur = sb.pop_front();
            n_vec++;
            if (!cur.imm && cur.cyc < cyc) begin
               n_bad++;
               $display("FAIL %s: check for cycle %0d missed, now cycle %0d", cur.name, cur.cyc, cyc);
            end else if (count !== cur.cnt || hex !== exp_hex(cur.cnt) || wrap !== cur.wrap ||
                         tick !== cur.tick || sq !== cur.sq) begin
               n_bad++;
               $display("FAIL %s @%0d: got cnt=%h hex=%h wrap=%b tick=%b sq=%b, want cnt=%h hex=%h wrap=%b tick=%b sq=%b",
                        cur.name, cyc, count, hex, wrap, tick, sq,
                        cur.cnt, exp_hex(cur.cnt), cur.wrap, cur.tick, cur.sq);
            end
         end
      end
   end

   task automatic push(input string nm, input int tgt, input logic [7:0] c, input logic w);
      exp_t e;
      e.cyc  = tgt;
      e.imm  = 1'b0;
      e.name = nm;
      e.cnt  = c;
      e.wrap = w;
      e.tick = ((tgt % 10) == 9);
      e.sq   = (((tgt / 10) % 2) == 1);
      sb.push_back(e);
   endtask

   task automatic push_reset_now(input string nm);
      exp_t e;
      e.cyc  = 0;
      e.imm  = 1'b1;
      e.name = nm;
      e.cnt  = 8'h00;
      e.wrap = 1'b0;
      e.tick = 1'b0;
      e.sq   = 1'b0;
      sb.push_back(e);
      -> chk_now;
   endtask

   task automatic wait_phase(input int p);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((cyc % 10) != p && n < 30);
      if ((cyc % 10) != p) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_phase: phase %0d not reached, cycle %0d", p, cyc);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d checks never reached, first %s", sb.size(), sb[0].name);
         sb.delete();
      end
   endtask

   task automatic do_load(input string nm, input logic [7:0] v, input logic b,
                          input logic u, input logic [7:0] exp_c);
      wait_phase(2);
      bcd      = b;
      up       = u;
      load_val = v;
      load     = 1'b1;
      push(nm, cyc + 1, exp_c, 1'b0);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic do_tick(input string nm, input logic [7:0] exp_c, input logic w);
      wait_phase(9);
      push(nm, cyc + 1, exp_c, w);
      if (w) push({nm, "_end"}, cyc + 2, exp_c, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values and divider
      #23;
      push_reset_now("reset_vals");
      @(negedge clk);
      rst_n = 1'b1;
      push("div_pre",   8, 8'h00, 1'b0);
      push("div_t10",   9, 8'h00, 1'b0);
      push("div_sq1",  10, 8'h00, 1'b0);
      push("div_t20",  19, 8'h00, 1'b0);
      push("div_sq0",  20, 8'h00, 1'b0);
      push("div_t30",  29, 8'h00, 1'b0);
      push("div_sq1b", 30, 8'h00, 1'b0);
      drain();

      // Hex up and wrap
      en = 1'b1;
      do_load("hex_ld_fe",   8'hFE, 1'b0, 1'b1, 8'hFE);
      do_tick("hex_up_ff",   8'hFF, 1'b0);
      do_tick("hex_up_wrap", 8'h00, 1'b1);
      do_load("hex_ld_ab",   8'hAB, 1'b0, 1'b1, 8'hAB);
      do_tick("hex_up_ac",   8'hAC, 1'b0);

      // BCD up
      do_load("bcd_ld_19",    8'h19, 1'b1, 1'b1, 8'h19);
      do_tick("bcd_up_20",    8'h20, 1'b0);
      do_load("bcd_ld_99",    8'h99, 1'b1, 1'b1, 8'h99);
      do_tick("bcd_up_wrap",  8'h00, 1'b1);
      do_load("bcd_ld_clamp", 8'h3A, 1'b1, 1'b1, 8'h39);
      do_tick("bcd_up_40",    8'h40, 1'b0);
      do_load("bcd_ld_c7",    8'hC7, 1'b1, 1'b1, 8'h97);

      // BCD and hex down
      do_load("bcd_ld_10",   8'h10, 1'b1, 1'b0, 8'h10);
      do_tick("bcd_dn_09",   8'h09, 1'b0);
      do_load("bcd_ld_00",   8'h00, 1'b1, 1'b0, 8'h00);
      do_tick("bcd_dn_wrap", 8'h99, 1'b1);
      do_load("hex_ld_00",   8'h00, 1'b0, 1'b0, 8'h00);
      do_tick("hex_dn_wrap", 8'hFF, 1'b1);
      do_tick("hex_dn_fe",   8'hFE, 1'b0);

      // Clear beats load beats a wrapping step
      do_load("prio_ld_ff", 8'hFF, 1'b0, 1'b1, 8'hFF);
      wait_phase(9);
      clr      = 1'b1;
      load     = 1'b1;
      load_val = 8'h55;
      push("prio_clr", cyc + 1, 8'h00, 1'b0);
      @(negedge clk);
      clr  = 1'b0;
      load = 1'b0;
      do_tick("prio_next", 8'h01, 1'b0);
      wait_phase(9);
      load     = 1'b1;
      load_val = 8'h33;
      push("prio_load", cyc + 1, 8'h33, 1'b0);
      @(negedge clk);
      load = 1'b0;

      // Enable low on a tick
      en = 1'b0;
      do_tick("en_off_hold", 8'h33, 1'b0);

      // Async reset mid-count
      do_load("rst_ld_05", 8'h05, 1'b0, 1'b1, 8'h05);
      drain();
      wait_phase(7);
      #2;
      rst_n = 1'b0;
      #1;
      push_reset_now("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push("rst_rel_1",  1, 8'h00, 1'b0);
      push("rst_rel_t",  9, 8'h00, 1'b0);
      push("rst_rel_sq", 10, 8'h00, 1'b0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
